// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Main control FSM for a multicycle MIPS datapath. It sequences
//            fetch, decode and execute steps for lw, sw, R-type, beq, addi
//            and j, and drives the datapath select, enable and write strobes.
// Ports    : clk, rst          - rising-edge clock, synchronous active-high reset
//            opcode, funct     - instruction fields taken from the IR
//            zero              - ALU zero flag, gates the PC write in BRANCH
//            alu_control       - ALU operation select
//            alu_src_a/b       - ALU operand muxes
//            pc_src, i_or_d    - PC source and memory address muxes
//            reg_dst, mem_to_reg - register-file write address / data muxes
//            ir_write, mem_write, reg_write, pc_en - write enables
//            state             - current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_funct_alu;

    assign state = r_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. opcode only matters in DECODE and MEMADR.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = MEMADR;
                    c_OP_RTYPE:       w_next = EXEC;
                    c_OP_BEQ:         w_next = BRANCH;
                    c_OP_ADDI:        w_next = ADDIEX;
                    c_OP_J:           w_next = JUMP;
                    default:          w_next = FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR; anything but sw is treated as a load.
            MEMADR:  w_next = (opcode == c_OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = MEMWB;
            EXEC:    w_next = ALUWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // R-type function decode, only consulted in EXEC
    always_comb begin
        w_funct_alu = c_ALU_ADD;
        case (funct)
            c_FN_ADD: w_funct_alu = c_ALU_ADD;
            c_FN_SUB: w_funct_alu = c_ALU_SUB;
            c_FN_AND: w_funct_alu = c_ALU_AND;
            c_FN_OR:  w_funct_alu = c_ALU_OR;
            c_FN_SLT: w_funct_alu = c_ALU_SLT;
            default:  w_funct_alu = c_ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except alu_control in EXEC and pc_en in BRANCH)
    // ------------------------------------------------------------------
    always_comb begin
        alu_control = c_ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        i_or_d      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        pc_en       = 1'b0;

        case (r_state)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_en     = 1'b1;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                i_or_d = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = w_funct_alu;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = c_ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase

        // While reset is held, present the FETCH muxing with every write
        // strobe suppressed, whatever state the register still holds.
        if (rst) begin
            alu_control = c_ALU_ADD;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b01;
            pc_src      = 2'b00;
            i_or_d      = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            ir_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            pc_en       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clk input 1 (rising-edge clock), rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL have these inputs: opcode input 6 (instr[31:26] from IR); funct input 6 (instr[5:0] from IR); zero input 1 (ALU zero flag).
REQ-003 The block SHALL have these datapath-select outputs: alu_control output 3 (ALU op); alu_src_a output 1 (0=PC, 1=reg A); alu_src_b output 2 (00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2); pc_src output 2 (00=ALU result, 01=ALUOut reg, 10=jump target).
REQ-004 The block SHALL have these control outputs: i_or_d output 1 (memory address, 0=PC, 1=ALUOut); reg_dst output 1 (0=rt, 1=rd); mem_to_reg output 1 (0=ALUOut, 1=mem data).
REQ-005 The block SHALL have these enable outputs: ir_write output 1; mem_write output 1; reg_write output 1; pc_en output 1; state output 4 (current state, debug).

Function
REQ-006 The FSM state register SHALL be 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-007 Transitions SHALL be: FETCH->DECODE.
REQ-008 DECODE->MEMADR (lw 100011, sw 101011), EXEC (000000), BRANCH (beq 000100), ADDIEX (addi 001000), JUMP (j 000010), FETCH (any other opcode).
REQ-009 MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB; and MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, and unused codes 12-15 ->FETCH.
REQ-010 Outputs SHALL be combinational from state (Moore), except alu_control in EXEC (from funct) and pc_en in BRANCH (from zero).
REQ-011 Any output not listed for a state SHALL be 0; alu_control not listed SHALL be 010.
REQ-012 FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, ir_write=1, pc_en=1.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_control=010.
REQ-014 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010.
REQ-015 MEMRD: i_or_d=1.
REQ-016 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
REQ-017 MEMWR: i_or_d=1, mem_write=1.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00; alu_control from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-019 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
REQ-020 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero.
REQ-022 JUMP: pc_src=10, pc_en=1.
REQ-023 Unused states 12-15 SHALL drive all outputs to their default values.
REQ-024 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
REQ-025 opcode and funct SHALL be sampled only in DECODE/MEMADR (transition) and EXEC (alu_control); changes in other states SHALL have no effect.
REQ-026 zero SHALL affect no output outside BRANCH.

Reset
REQ-027 When rst=1 at a rising edge, state SHALL become FETCH regardless of current state, including mid-instruction.
REQ-028 While rst=1, ir_write, mem_write, reg_write and pc_en SHALL be forced to 0; the other outputs SHALL take their FETCH values.
REQ-029 On the first edge after rst deasserts, the FSM SHALL leave FETCH->DECODE with the FETCH enables active in the preceding cycle.

Verification
REQ-030 The bench SHALL cover lw: opcode=100011 from reset release -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-031 The bench SHALL cover the R-type funct sweep: opcode=000000, funct in {100000,100010,100100,100101,101010,111111} -> alu_control in EXEC = 010,110,000,001,111,010; ALUWB reg_dst=1.
REQ-032 The bench SHALL cover beq: opcode=000100, zero=1 -> pc_en=1, pc_src=01 in BRANCH; with zero=0 -> pc_en=0; zero toggling in FETCH leaves pc_en=1.
REQ-033 The bench SHALL cover sw and j: opcode=101011 -> states 0,1,2,5,0 with mem_write=1 only in state 5; opcode=000010 -> states 0,1,11,0 with pc_src=10, pc_en=1 in state 11.
REQ-034 The bench SHALL cover an illegal opcode: opcode=111111 -> states 0,1,0, with no reg_write or mem_write pulse.
REQ-035 The bench SHALL cover reset mid-operation: rst=1 asserted in MEMRD -> next state 0; all write enables 0 while rst=1; normal FETCH resumes after release.
